// File: rtl/rv_mem_arbiter.sv
// rv_mem_arbiter
//   Shares one single-port unified memory between the core's instruction-fetch
//   port and data port. Each accepted request becomes exactly one memory
//   transaction; the winner gets a single-cycle valid pulse on completion.
//   A watchdog aborts transactions the memory never acknowledges and sets a
//   sticky error flag.
//
// Ports
//   i_arb_clk, i_arb_rst       clock, synchronous active-high reset
//   i_arb_i_*                  fetch request (req/addr), held until o_arb_i_valid
//   o_arb_i_rdata/valid        fetched word, one-cycle completion pulse
//   i_arb_d_*                  data request (req/we/addr/wd/bytectrl)
//   o_arb_d_rdata/valid        load data (0 for stores), completion pulse
//   o_arb_mem_*                registered memory request, stable while pending
//   i_arb_mem_ack/rd           memory completion strobe and read data
//   o_arb_busy                 high in any state other than IDLE
//   o_arb_err                  sticky watchdog timeout flag
//
// Build option
//   RV_ARB_ROUND_ROBIN_EN      defined: ties go to the port not granted last
//                              undefined: data port always wins ties
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | sample requesters, pick a winner
// MEM_I  | fetch transaction outstanding, waiting for ack or timeout
// MEM_D  | data transaction outstanding, waiting for ack or timeout
// RESP   | one-cycle valid pulse to the winner, then back to IDLE

module rv_mem_arbiter #(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 7
) (
  input  logic            i_arb_clk,
  input  logic            i_arb_rst,
  input  logic            i_arb_i_req,
  input  logic [XLEN-1:0] i_arb_i_addr,
  output logic [31:0]     o_arb_i_rdata,
  output logic            o_arb_i_valid,
  input  logic            i_arb_d_req,
  input  logic            i_arb_d_we,
  input  logic [XLEN-1:0] i_arb_d_addr,
  input  logic [XLEN-1:0] i_arb_d_wd,
  input  logic [2:0]      i_arb_d_bytectrl,
  output logic [XLEN-1:0] o_arb_d_rdata,
  output logic            o_arb_d_valid,
  output logic            o_arb_mem_req,
  output logic            o_arb_mem_we,
  output logic [XLEN-1:0] o_arb_mem_addr,
  output logic [XLEN-1:0] o_arb_mem_wd,
  output logic [2:0]      o_arb_mem_bytectrl,
  input  logic            i_arb_mem_ack,
  input  logic [XLEN-1:0] i_arb_mem_rd,
  output logic            o_arb_busy,
  output logic            o_arb_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MEM_I = 2'd1,
    S_MEM_D = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam int              TO_LAST_I = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TO_LAST_I);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_timeout;
  logic             w_grant_d;
  logic             w_grant_i;

  // A zero TIMEOUT_CYC disables the watchdog entirely.
  assign w_timeout = (TIMEOUT_CYC != 0) && (r_cnt == TO_LAST);

`ifdef RV_ARB_ROUND_ROBIN_EN
  // 1 = data port granted last. Reset value means "instruction last",
  // so the first tie after reset goes to the data port.
  logic r_last_d;

  assign w_grant_d = i_arb_d_req && (!i_arb_i_req || !r_last_d);

  always_ff @(posedge i_arb_clk) begin
    if (i_arb_rst) begin
      r_last_d <= 1'b0;
    end else if (r_state == S_IDLE && (i_arb_d_req || i_arb_i_req)) begin
      r_last_d <= w_grant_d;
    end
  end
`else
  assign w_grant_d = i_arb_d_req;
`endif

  assign w_grant_i  = i_arb_i_req && !w_grant_d;
  assign o_arb_busy = (r_state != S_IDLE);

  always_ff @(posedge i_arb_clk) begin
    if (i_arb_rst) begin
      r_state            <= S_IDLE;
      r_cnt              <= '0;
      o_arb_i_rdata      <= '0;
      o_arb_i_valid      <= 1'b0;
      o_arb_d_rdata      <= '0;
      o_arb_d_valid      <= 1'b0;
      o_arb_mem_req      <= 1'b0;
      o_arb_mem_we       <= 1'b0;
      o_arb_mem_addr     <= '0;
      o_arb_mem_wd       <= '0;
      o_arb_mem_bytectrl <= 3'd0;
      o_arb_err          <= 1'b0;
    end else begin
      o_arb_i_valid <= 1'b0;
      o_arb_d_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_d) begin
            o_arb_mem_req      <= 1'b1;
            o_arb_mem_we       <= i_arb_d_we;
            o_arb_mem_addr     <= i_arb_d_addr;
            o_arb_mem_wd       <= i_arb_d_wd;
            o_arb_mem_bytectrl <= i_arb_d_bytectrl;
            r_cnt              <= '0;
            r_state            <= S_MEM_D;
          end else if (w_grant_i) begin
            o_arb_mem_req      <= 1'b1;
            o_arb_mem_we       <= 1'b0;
            o_arb_mem_addr     <= i_arb_i_addr;
            o_arb_mem_wd       <= '0;
            o_arb_mem_bytectrl <= 3'd0;
            r_cnt              <= '0;
            r_state            <= S_MEM_I;
          end
        end
        S_MEM_I, S_MEM_D: begin
          // Ack is checked first so an ack on the last watchdog cycle wins.
          if (i_arb_mem_ack) begin
            o_arb_mem_req <= 1'b0;
            r_state       <= S_RESP;
            if (r_state == S_MEM_I) begin
              o_arb_i_rdata <= i_arb_mem_rd[31:0];
              o_arb_i_valid <= 1'b1;
            end else begin
              o_arb_d_rdata <= o_arb_mem_we ? '0 : i_arb_mem_rd;
              o_arb_d_valid <= 1'b1;
            end
          end else if (w_timeout) begin
            o_arb_mem_req <= 1'b0;
            o_arb_err     <= 1'b1;
            r_state       <= S_RESP;
            if (r_state == S_MEM_I) begin
              o_arb_i_rdata <= '0;
              o_arb_i_valid <= 1'b1;
            end else begin
              o_arb_d_rdata <= '0;
              o_arb_d_valid <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_mem_arbiter.sv
module tb_rv_mem_arbiter;

  localparam int XLEN = 32;
  localparam int TO   = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_req, d_req, d_we, mem_ack;
  logic [31:0]     i_addr, d_addr, d_wd, mem_rd;
  logic [2:0]      d_bc;
  logic [31:0]     o_i_rdata, o_d_rdata, o_mem_addr, o_mem_wd;
  logic            o_i_valid, o_d_valid, o_mem_req, o_mem_we, o_busy, o_err;
  logic [2:0]      o_mem_bc;

  always #5 clk = ~clk;

  rv_mem_arbiter #(.XLEN(XLEN), .TIMEOUT_CYC(TO), .CNT_W(7)) dut (
    .i_arb_clk(clk), .i_arb_rst(rst),
    .i_arb_i_req(i_req), .i_arb_i_addr(i_addr),
    .o_arb_i_rdata(o_i_rdata), .o_arb_i_valid(o_i_valid),
    .i_arb_d_req(d_req), .i_arb_d_we(d_we), .i_arb_d_addr(d_addr),
    .i_arb_d_wd(d_wd), .i_arb_d_bytectrl(d_bc),
    .o_arb_d_rdata(o_d_rdata), .o_arb_d_valid(o_d_valid),
    .o_arb_mem_req(o_mem_req), .o_arb_mem_we(o_mem_we),
    .o_arb_mem_addr(o_mem_addr), .o_arb_mem_wd(o_mem_wd),
    .o_arb_mem_bytectrl(o_mem_bc),
    .i_arb_mem_ack(mem_ack), .i_arb_mem_rd(mem_rd),
    .o_arb_busy(o_busy), .o_arb_err(o_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [2:0]  bc;
    int          dly;
    logic [31:0] rd;
  } plan_t;

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  plan_t       plan_q[$];
  exp_t        exp_q[$];
  bit          m_last_d = 1'b0;
  bit          m_err    = 1'b0;
  logic [31:0] mon_last_i = '0;
  logic [31:0] mon_last_d = '0;

  // Arbitration rule of the reference model: returns 1 when data wins.
  task automatic pick(input bit pi, input bit pd, output bit w);
`ifdef RV_ARB_ROUND_ROBIN_EN
    if (pi && pd) w = !m_last_d;
    else          w = pd;
`else
    w = pd;
`endif
    m_last_d = w;
  endtask

  function automatic int exp_hi(input int dly);
    return ((dly < TO) ? dly : TO - 1) + 1;
  endfunction

  // Monitor: pops the expected response whenever a valid pulse appears.
  bit prev_req = 1'b0;
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      chk("busy_vs_activity", {31'd0, o_busy}, {31'd0, o_mem_req | o_i_valid | o_d_valid});
      if (o_i_valid && o_d_valid) fail_now("both_valid");
      if (o_i_valid || o_d_valid) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_valid");
        end else begin
          e = exp_q.pop_front();
          chk("valid_port", {31'd0, o_d_valid}, {31'd0, e.is_d});
          chk("valid_after_mem", {31'd0, prev_req}, 32'd1);
          chk("err_flag", {31'd0, o_err}, {31'd0, e.err});
          if (e.is_d) begin
            chk("d_rdata", o_d_rdata, e.rdata);
            chk("i_rdata_held", o_i_rdata, mon_last_i);
            mon_last_d = e.rdata;
          end else begin
            chk("i_rdata", o_i_rdata, e.rdata);
            chk("d_rdata_held", o_d_rdata, mon_last_d);
            mon_last_i = e.rdata;
          end
        end
      end
      prev_req = o_mem_req;
    end
  end

  // Memory responder: follows the plan queue in grant order.
  initial begin
    plan_t cur;
    bit    active = 1'b0;
    bit    late   = 1'b0;
    int    hi     = 0;
    mem_ack = 1'b0;
    mem_rd  = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      mem_rd  = $urandom;
      if (late) begin
        mem_ack = 1'b1;
        late    = 1'b0;
      end
      if (active && !o_mem_req) begin
        if (rst) late = 1'b1;
        else     chk("mem_req_cycles", hi, exp_hi(cur.dly));
        active = 1'b0;
      end
      if (!active && o_mem_req) begin
        if (plan_q.size() == 0) begin
          fail_now("unexpected_mem_req");
          cur = '{is_d: 1'b0, we: 1'b0, addr: o_mem_addr, wd: '0, bc: o_mem_bc, dly: 0, rd: '0};
        end else begin
          cur = plan_q.pop_front();
        end
        active = 1'b1;
        hi     = 0;
      end
      if (active) begin
        chk("mem_addr", o_mem_addr, cur.addr);
        chk("mem_we", {31'd0, o_mem_we}, {31'd0, cur.we});
        chk("mem_bytectrl", {29'd0, o_mem_bc}, {29'd0, cur.bc});
        if (cur.is_d) chk("mem_wd", o_mem_wd, cur.wd);
        hi++;
        if (hi - 1 == cur.dly) begin
          mem_ack = 1'b1;
          mem_rd  = cur.rd;
        end
      end
    end
  end

  task automatic rand_fields();
    i_addr = $urandom;
    d_addr = $urandom;
    d_wd   = $urandom;
    d_we   = 1'($urandom_range(0, 1));
    d_bc   = 3'($urandom_range(0, 7));
  endtask

  // Issue one group of requests; expected responses are pushed up front.
  // hold=1 keeps both reqs asserted for n completions.
  task automatic run_group(input bit pi, input bit pd, input bit hold, input int n,
                           input int dly, input logic [31:0] rdv, input bit rnd_rd,
                           input bit scramble);
    bit    pend_i = pi;
    bit    pend_d = pd;
    bit    w;
    bit    to;
    int    got = 0;
    int    cyc = 0;
    plan_t p;
    exp_t  e;
    for (int k = 0; k < n; k++) begin
      pick(pend_i, pend_d, w);
      p.is_d = w;
      p.we   = w ? d_we : 1'b0;
      p.addr = w ? d_addr : i_addr;
      p.wd   = d_wd;
      p.bc   = w ? d_bc : 3'd0;
      p.dly  = (dly < 0) ? int'($urandom_range(0, 5)) : dly;
      p.rd   = rnd_rd ? $urandom : rdv;
      to     = (p.dly >= TO);
      if (to) m_err = 1'b1;
      e.is_d  = w;
      e.rdata = to ? 32'd0 : ((w && p.we) ? 32'd0 : p.rd);
      e.err   = m_err;
      plan_q.push_back(p);
      exp_q.push_back(e);
      if (!hold) begin
        if (w) pend_d = 1'b0;
        else   pend_i = 1'b0;
      end
    end
    i_req = pi;
    d_req = pd;
    while (got < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (o_i_valid) begin got++; if (!hold) i_req = 1'b0; end
      if (o_d_valid) begin got++; if (!hold) d_req = 1'b0; end
      if (scramble && o_mem_req) rand_fields();
    end
    if (got < n) begin
      fail_now("group_completion_timeout");
      plan_q.delete();
      exp_q.delete();
    end
    i_req = 1'b0;
    d_req = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_time_limit");
    $fatal(1, "time limit");
  end

  initial begin
    plan_t p;
    rst = 1'b1;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wd = '0; d_bc = 3'd0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", {31'd0, o_mem_req}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_i_valid", {31'd0, o_i_valid}, 32'd0);
    chk("rst_d_valid", {31'd0, o_d_valid}, 32'd0);
    chk("rst_err", {31'd0, o_err}, 32'd0);
    chk("rst_i_rdata", o_i_rdata, 32'd0);
    chk("rst_d_rdata", o_d_rdata, 32'd0);
    chk("rst_mem_addr", o_mem_addr, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Fetch only, ack two cycles after mem_req rises.
    i_addr = 32'h100;
    run_group(1'b1, 1'b0, 1'b0, 1, 2, 32'h00500093, 1'b0, 1'b1);

    // Store with immediate ack.
    d_we = 1'b1; d_addr = 32'h2004; d_wd = 32'hDEADBEEF; d_bc = 3'd2;
    run_group(1'b0, 1'b1, 1'b0, 1, 0, 32'h12345678, 1'b0, 1'b1);

    // Ack on the last watchdog cycle returns data, no error.
    i_addr = 32'h400;
    run_group(1'b1, 1'b0, 1'b0, 1, TO - 1, 32'hCAFEF00D, 1'b0, 1'b1);
    chk("err_after_coincident_ack", {31'd0, o_err}, 32'd0);

    // Both requests held through four completions.
    rand_fields();
    run_group(1'b1, 1'b1, 1'b1, 4, 1, 32'd0, 1'b1, 1'b0);

    // Memory never answers.
    rand_fields();
    d_we = 1'b0;
    run_group(1'b0, 1'b1, 1'b0, 1, 9, 32'd0, 1'b1, 1'b1);
    chk("err_after_timeout", {31'd0, o_err}, 32'd1);

    for (int g = 0; g < 40; g++) begin
      int pat;
      bit pi, pd;
      rand_fields();
      pat = int'($urandom_range(0, 2));
      pi  = (pat != 1);
      pd  = (pat != 0);
      run_group(pi, pd, 1'b0, int'(pi) + int'(pd), -1, 32'd0, 1'b1, pi ^ pd);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    chk("err_sticky", {31'd0, o_err}, 32'd1);

    // Reset in the middle of a data transaction, followed by a late ack.
    rand_fields();
    d_we = 1'b0;
    p = '{is_d: 1'b1, we: 1'b0, addr: d_addr, wd: d_wd, bc: d_bc, dly: 2, rd: 32'h55AA55AA};
    plan_q.push_back(p);
    d_req = 1'b1;
    @(negedge clk);
    chk("pre_reset_mem_req", {31'd0, o_mem_req}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    d_req = 1'b0;
    m_err = 1'b0; m_last_d = 1'b0; mon_last_i = '0; mon_last_d = '0;
    chk("mid_rst_mem_req", {31'd0, o_mem_req}, 32'd0);
    chk("mid_rst_busy", {31'd0, o_busy}, 32'd0);
    chk("mid_rst_d_valid", {31'd0, o_d_valid}, 32'd0);
    chk("mid_rst_err", {31'd0, o_err}, 32'd0);
    chk("mid_rst_i_rdata", o_i_rdata, 32'd0);
    chk("mid_rst_d_rdata", o_d_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("late_ack_mem_req", {31'd0, o_mem_req}, 32'd0);
      chk("late_ack_busy", {31'd0, o_busy}, 32'd0);
    end

    // Normal operation resumes after reset with the error cleared.
    rand_fields();
    run_group(1'b1, 1'b0, 1'b0, 1, 1, 32'd0, 1'b1, 1'b1);
    chk("err_after_reset", {31'd0, o_err}, 32'd0);
    chk("queues_drained", plan_q.size() + exp_q.size(), 32'd0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
